// File: rtl/regfile_dump_reader.sv
// Walks a range of register-file indices through one combinational read port and
// streams each word out over valid/ready, keeping a running sum of emitted words.
module regfile_dump_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] FirstReg,
    input  logic [ADDR_WIDTH-1:0] LastReg,
    output logic [ADDR_WIDTH-1:0] ReadReg,
    input  logic [DATA_WIDTH-1:0] ReadData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [ADDR_WIDTH-1:0] OutReg,
    output logic [DATA_WIDTH-1:0] OutData,
    output logic [DATA_WIDTH-1:0] Checksum,
    output logic                  Busy,
    output logic                  Done
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } stateT;

    stateT                 stateReg;
    logic [ADDR_WIDTH-1:0] ptrReg;
    logic [ADDR_WIDTH-1:0] lastIdxReg;

    // The read port only sees the pointer while a capture is pending.
    assign ReadReg = (stateReg == FETCH) ? ptrReg : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stateReg   <= IDLE;
            ptrReg     <= '0;
            lastIdxReg <= '0;
            OutValid   <= 1'b0;
            OutReg     <= '0;
            OutData    <= '0;
            Checksum   <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (Start) begin
                        ptrReg     <= FirstReg;
                        lastIdxReg <= LastReg;
                        Checksum   <= '0;
                        Busy       <= 1'b1;
                        stateReg   <= FETCH;
                    end
                end
                FETCH: begin
                    OutData  <= ReadData;
                    OutReg   <= ptrReg;
                    OutValid <= 1'b1;
                    Checksum <= Checksum + ReadData;
                    stateReg <= SEND;
                end
                SEND: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        if (ptrReg == lastIdxReg) begin
                            Done     <= 1'b1;
                            stateReg <= DONE;
                        end else begin
                            // Index wraps naturally at the top of the file.
                            ptrReg   <= ptrReg + 1'b1;
                            stateReg <= FETCH;
                        end
                    end
                end
                DONE: begin
                    Busy     <= 1'b0;
                    stateReg <= IDLE;
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader: a register-file array plus a queue-based
// model of the expected word stream, checksum and Done timing.
module tb_regfile_dump_reader;

    logic        clk;
    logic        rstN;
    logic        start;
    logic [4:0]  firstReg;
    logic [4:0]  lastReg;
    logic [4:0]  readReg;
    logic [31:0] readData;
    logic        outValid;
    logic        outReady;
    logic [4:0]  outReg;
    logic [31:0] outData;
    logic [31:0] checksum;
    logic        busy;
    logic        done;

    logic [31:0] rf [32];
    int nVec = 0;
    int nBad = 0;

    assign readData = rf[readReg];

    regfile_dump_reader #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .CLK(clk), .RST(rstN), .Start(start), .FirstReg(firstReg), .LastReg(lastReg),
        .ReadReg(readReg), .ReadData(readData), .OutValid(outValid), .OutReady(outReady),
        .OutReg(outReg), .OutData(outData), .Checksum(checksum), .Busy(busy), .Done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic preloadTriple();
        for (int i = 0; i < 32; i++) rf[i] = 32'(3 * i);
    endtask

    // mode 0: always ready, 1: random ready, 2: ready only after 3 stalled cycles per word.
    // expDoneCycle > 0 checks the cycle (counted from the Start edge) in which Done is high.
    task automatic runDump(input int first, input int last, input int mode,
                           input int expDoneCycle, input logic [31:0] expSum);
        int          n;
        int          c;
        int          stallCnt;
        bit          gotDone;
        bit          rdy;
        logic [4:0]  expReg [$];
        logic [31:0] expDat [$];
        logic [31:0] sum;
        n = ((last - first + 32) % 32) + 1;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            expReg.push_back(5'((first + i) % 32));
            expDat.push_back(rf[(first + i) % 32]);
            sum += rf[(first + i) % 32];
        end
        if (expSum != 32'hFFFF_FFFF) chk("modelSum", sum, expSum);
        $display("dump first=%0d last=%0d words=%0d mode=%0d", first, last, n, mode);
        @(negedge clk);
        start = 1'b1; firstReg = 5'(first); lastReg = 5'(last); outReady = 1'b0;
        @(negedge clk);
        start = 1'b0; firstReg = 5'($urandom); lastReg = 5'($urandom);
        c = 1; stallCnt = 0; gotDone = 0;
        while (!gotDone && c < 400) begin
            chk("busy", 32'(busy), 1);
            if (done) begin
                gotDone = 1;
                chk("wordsLeftAtDone", expReg.size(), 0);
                chk("checksum", checksum, sum);
                chk("validAtDone", 32'(outValid), 0);
                if (expDoneCycle > 0) chk("doneCycle", c, expDoneCycle);
                start = 1'b1; firstReg = 5'($urandom); lastReg = 5'($urandom);
                outReady = 1'($urandom_range(0, 1));
            end else if (outValid) begin
                if (expReg.size() == 0) begin
                    chk("extraWord", 32'(outValid), 0);
                    rdy = 1'b1;
                end else begin
                    chk("outReg", 32'(outReg), 32'(expReg[0]));
                    chk("outData", outData, expDat[0]);
                    case (mode)
                        0:       rdy = 1'b1;
                        1:       rdy = 1'($urandom_range(0, 1));
                        default: rdy = (stallCnt >= 3);
                    endcase
                    if (rdy) begin
                        $display("word reg=%0d data=0x%08h stalls=%0d", outReg, outData, stallCnt);
                        void'(expReg.pop_front());
                        void'(expDat.pop_front());
                        stallCnt = 0;
                    end else begin
                        stallCnt++;
                    end
                end
                outReady = rdy;
            end else begin
                if (expReg.size() > 0) chk("readReg", 32'(readReg), 32'(expReg[0]));
                outReady = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            c++;
        end
        if (!gotDone) chk("doneTimeout", 0, 1);
        start = 1'b0;
        chk("busyAfter", 32'(busy), 0);
        chk("doneAfter", 32'(done), 0);
        chk("readRegIdle", 32'(readReg), 0);
        chk("checksumHold", checksum, sum);
        @(negedge clk);
        chk("startInDoneIgnored", 32'(busy), 0);
    endtask

    initial begin
        int idx;
        bit aborted;
        logic [4:0] abortSeq [2];
        rstN = 1'b0; start = 1'b1; firstReg = 5'd7; lastReg = 5'd3; outReady = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;

        // Reset held with Start asserted and noisy inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            firstReg = 5'($urandom); lastReg = 5'($urandom); outReady = 1'($urandom_range(0, 1));
            chk("rstValid", 32'(outValid), 0);
            chk("rstBusy", 32'(busy), 0);
            chk("rstDone", 32'(done), 0);
            chk("rstReadReg", 32'(readReg), 0);
            chk("rstOutReg", 32'(outReg), 0);
            chk("rstOutData", outData, 0);
            chk("rstChecksum", checksum, 0);
        end
        start = 1'b0;
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idleBusy", 32'(busy), 0);
            chk("idleValid", 32'(outValid), 0);
            chk("idleChecksum", checksum, 0);
        end

        preloadTriple();
        runDump(0, 31, 0, 65, 32'd1488);
        runDump(2, 4, 2, 0, 32'd27);
        runDump(30, 1, 0, 9, 32'd186);
        runDump(5, 5, 0, 3, 32'd15);

        // Abort: second Start while busy is ignored, reset during reg 11's SEND
        abortSeq[0] = 5'd10; abortSeq[1] = 5'd11;
        $display("abort test first=10 last=12");
        @(negedge clk);
        start = 1'b1; firstReg = 5'd10; lastReg = 5'd12; outReady = 1'b1;
        @(negedge clk);
        start = 1'b0; idx = 0; aborted = 0;
        for (int c = 1; c < 20 && !aborted; c++) begin
            if (c == 2 || c == 3) begin
                start = 1'b1; firstReg = 5'd0; lastReg = 5'd3;
            end else begin
                start = 1'b0;
            end
            if (outValid) begin
                chk("abortOutReg", 32'(outReg), 32'(abortSeq[idx]));
                chk("abortOutData", outData, rf[abortSeq[idx]]);
                if (idx == 1) begin
                    rstN = 1'b0;
                    #1;
                    chk("abortValid", 32'(outValid), 0);
                    chk("abortBusy", 32'(busy), 0);
                    chk("abortChecksum", checksum, 0);
                    aborted = 1;
                end else begin
                    idx++;
                end
            end
            if (!aborted) @(negedge clk);
        end
        if (!aborted) chk("abortReached", 0, 1);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abortNoDone", 32'(done), 0);
        end
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postAbortDone", 32'(done), 0);
            chk("postAbortBusy", 32'(busy), 0);
        end
        runDump(10, 12, 0, 7, 32'd99);

        // Random contents, ranges and back-pressure
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            runDump(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1, 0, 32'hFFFF_FFFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential read-out engine that walks a range of the 32×32 register file through one of its combinational read ports and streams each register's contents out over a valid/ready handshake. It keeps a running 32-bit checksum of the words it streams. It is the reading end of the register-file interface, sitting beside the CPU datapath for debug/state dump. It drives one `ReadReg` port and consumes the matching `ReadData`; it never writes the register file.

## Interface
- `ADDR_WIDTH`, default 5: register index width; 32 registers.
- `DATA_WIDTH`, default 32: register word width.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-low; `RST=0` forces the reset state immediately.
- `Start`  in  1  request a dump; sampled only in IDLE.
- `FirstReg`  in  5  first register index; latched when `Start` is accepted.
- `LastReg`  in  5  last register index, inclusive; latched when `Start` is accepted.
- `ReadReg`  out  5  index to the register-file read port.
- `ReadData`  in  32  combinational read data from the register file.
- `OutValid`  out  1  `OutReg`/`OutData` hold a valid word.
- `OutReady`  in  1  consumer accepts the word.
- `OutReg`  out  5  index of the word being presented.
- `OutData`  out  32  register contents being presented.
- `Checksum`  out  32  running sum of words captured in the current dump.
- `Busy`  out  1  high in any state except IDLE.
- `Done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE:
  - `ReadReg` = 0.
  - When `Start`=1 at an edge: latch `FirstReg`/`LastReg`, set ptr←FirstReg, clear `Checksum` to 0, and go to FETCH.
- FETCH:
  - `ReadReg` = ptr, combinationally.
  - At the next edge: `OutData`←`ReadData`, `OutReg`←ptr, `OutValid`←1, `Checksum`←`Checksum`+`ReadData` (mod 2^32, carry dropped), then go to SEND.
- SEND:
  - `OutValid`=1. `OutReg` and `OutData` are held stable until the handshake.
  - On an edge with `OutValid`&`OutReady`: `OutValid`←0.
    - If ptr==LastReg, go to DONE.
    - Otherwise ptr←ptr+1 (5-bit, wraps 31→0) and go to FETCH.
- DONE: `Done`=1 for exactly one cycle, then go to IDLE. `Checksum` holds its final value until the next accepted `Start`.
- Range rule: words emitted = ((LastReg−FirstReg) mod 32)+1.
  - LastReg<FirstReg wraps through 31→0.
  - FirstReg==LastReg emits exactly one word.
- `Start` is ignored while `Busy`=1. A new `Start` in the same cycle as the DONE pulse is also ignored.
- A register-file write during FETCH is not arbitrated: the captured value is whatever `ReadData` shows at that FETCH edge.
- Register 0 is read like any other register; the block does not special-case it.

## Timing
- Reset values: state=IDLE, ptr=0, `ReadReg`=0, `OutValid`=0, `OutReg`=0, `OutData`=0, `Checksum`=0, `Busy`=0, `Done`=0.
- Reset mid-dump aborts immediately, with no final `Done` pulse. After `RST` returns to 1, the block waits in IDLE for a new `Start`.
- Start to first valid word: `Start` is accepted at edge k. FETCH runs in cycle k+1, and `OutValid`=1 from edge k+1 to edge k+2.
- Throughput: 2 cycles per word minimum (FETCH+SEND) when `OutReady` stays 1. Each cycle of back-pressure adds one cycle.
- N-word dump with `OutReady`=1, Start at edge 0:
  - The last handshake is at edge 2N.
  - `Done`=1 during cycle 2N+1.
  - The block is back in IDLE at edge 2N+1.
- `OutValid` never drops without a handshake. `OutReady` is don't-care when `OutValid`=0.
- `Busy` rises at the edge that accepts `Start` and falls at the edge leaving DONE.

## Test plan
- Reset: hold `RST`=0 with `Start`=1 and random inputs → every output is 0 and no `OutValid`. Release `RST` → outputs stay 0 until `Start`.
- Full dump: preload reg i=3·i (reg0 reads 0), then First=0, Last=31, `OutReady`=1 → 32 words (0,0),(1,3)…(31,93) in order, one every 2 cycles. `Checksum`=1488 (0x5D0). `Done` pulses once, in cycle 65 after the Start edge.
- Back-pressure: First=2, Last=4, `OutReady` low for 3 cycles on each word → `OutReg`/`OutData` stay constant while stalled. Words (2,6),(3,9),(4,12) are each emitted exactly once; `Checksum`=27.
- Wrap-around: First=30, Last=1 → words for regs 30,31,0,1 (90,93,0,3); `Checksum`=186.
- Single word: First=Last=5 → one word (5,15); `Done` in cycle 3 after the Start edge; `Checksum`=15.
- Abort and ignore: pulse `Start` with First=0, Last=3 while `Busy`=1 on a dump of First=10, Last=12 → the second request is ignored. Assert `RST`=0 during reg 11's SEND → `OutValid` falls to 0 immediately and there is no `Done`. A new Start afterwards dumps cleanly.
